// File: rtl/ns_arbt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ns_arbt_pkg                                                                |
// | Shared types and helpers for the ns_gnrl arbitration set.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ns_arbt_pkg;

  localparam int C_WGT_W_DEF = 4;

  typedef logic [C_WGT_W_DEF-1:0] wgt_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reset pointer sits on the last index so the first circular search starts at 0.
  function automatic int rst_ptr(input int n);
    return n - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ns_gnrl_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ns_gnrl_rr_pick                                                            |
// | Combinational circular first-one search starting at start_id.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ns_gnrl_rr_pick
  import ns_arbt_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req_vec,
  input  logic [ID_W-1:0] start_id,
  output logic [N-1:0]    pick_oh,
  output logic [ID_W-1:0] pick_id,
  output logic            pick_fnd
);

  localparam int C_PW = $clog2(2 * N);

  logic [2*N-1:0]  w_mask;
  logic [2*N-1:0]  w_dbl;
  logic [C_PW-1:0] w_pos;

  // Lower copy masked below start_id; upper copy supplies the wrap-around.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 2 * N; i++) begin
      w_mask[i] = (i >= N) || (i >= int'(start_id));
    end
    w_dbl    = {req_vec, req_vec} & w_mask;
    w_pos    = '0;
    pick_fnd = 1'b0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        w_pos    = C_PW'(i);
        pick_fnd = 1'b1;
      end
    end
    pick_id = (w_pos >= C_PW'(N)) ? ID_W'(w_pos - C_PW'(N)) : ID_W'(w_pos);
    pick_oh = '0;
    if (pick_fnd) begin
      pick_oh[pick_id] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ns_gnrl_wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ns_gnrl_wrr_arbiter                                                        |
// | Weighted round-robin arbiter, valid/ready grant, optional packet lock      |
// | enabled by defining NS_WRR_LOCK_EN.                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ns_gnrl_wrr_arbiter
  import ns_arbt_pkg::*;
#(
  parameter int ARBT_NUM = 4,
  parameter int WGT_W    = 4,
  parameter int ID_W     = id_width(ARBT_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ARBT_NUM-1:0]       req_vec,
  input  logic [ARBT_NUM-1:0]       req_last,
  input  logic [ARBT_NUM*WGT_W-1:0] wgt_vec,
  input  logic                      wgt_load,
  input  logic                      grt_rdy,
  output logic                      grt_vld,
  output logic [ARBT_NUM-1:0]       grt_vec,
  output logic [ID_W-1:0]           grt_id
);

  typedef logic [WGT_W-1:0] wgt_w_t;

  localparam logic [0:0]          ST_IDLE   = 1'b0;
  localparam logic [0:0]          ST_OWN    = 1'b1;
  localparam logic [ID_W-1:0]     C_RST_PTR = ID_W'(rst_ptr(ARBT_NUM));
  localparam logic [ID_W-1:0]     C_LAST    = ID_W'(ARBT_NUM - 1);
  localparam logic [ARBT_NUM-1:0] C_ONE     = ARBT_NUM'(1);

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptr_nxt;
  wgt_w_t          r_cred;
  wgt_w_t          w_cred_nxt;
  wgt_w_t          r_wgt [ARBT_NUM];

  logic                w_locked;
  logic                w_own;
  logic                w_keep;
  logic                w_win_vld;
  logic [ID_W-1:0]     w_win_id;
  logic                w_xfer;
  logic [ID_W-1:0]     w_start;
  logic [ARBT_NUM-1:0] w_pick_oh;
  logic [ID_W-1:0]     w_pick_id;
  logic                w_pick_fnd;

  assign w_start = (r_ptr == C_LAST) ? '0 : r_ptr + 1'b1;

  ns_gnrl_rr_pick #(
    .N    (ARBT_NUM),
    .ID_W (ID_W)
  ) u_pick (
    .req_vec  (req_vec),
    .start_id (w_start),
    .pick_oh  (w_pick_oh),
    .pick_id  (w_pick_id),
    .pick_fnd (w_pick_fnd)
  );

  assign w_own     = (r_state == ST_OWN);
  assign w_keep    = w_own && req_vec[r_ptr] && ((r_cred != '0) || w_locked);
  // A held lock with the owner's request gone blocks everyone else.
  assign w_win_vld = w_keep || (!w_locked && w_pick_fnd);
  assign w_win_id  = w_keep ? r_ptr : w_pick_id;
  assign w_xfer    = w_win_vld && grt_rdy;

`ifdef NS_WRR_LOCK_EN
  logic r_locked;
  logic w_locked_nxt;

  assign w_locked = r_locked;

  always_comb begin
    w_locked_nxt = r_locked;
    if (w_xfer) begin
      w_locked_nxt = ~req_last[w_win_id];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked <= 1'b0;
    end else begin
      r_locked <= w_locked_nxt;
    end
  end
`else
  logic w_locked_nxt;
  logic w_unused_last;

  assign w_locked      = 1'b0;
  assign w_locked_nxt  = 1'b0;
  assign w_unused_last = ^req_last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= C_RST_PTR;
      r_cred  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cred  <= w_cred_nxt;
    end
  end

  // A same-cycle wgt_load does not reach cred: it reads the old r_wgt.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cred_nxt  = r_cred;
    if (w_xfer) begin
      if (w_keep) begin
        w_cred_nxt = (r_cred == '0) ? '0 : r_cred - 1'b1;
      end else begin
        w_ptr_nxt  = w_pick_id;
        w_cred_nxt = r_wgt[w_pick_id];
      end
      w_state_nxt = ((w_cred_nxt == '0) && !w_locked_nxt) ? ST_IDLE : ST_OWN;
    end
  end

  always_comb begin
    grt_vld = w_win_vld;
    grt_vec = '0;
    grt_id  = '0;
    if (w_win_vld) begin
      grt_id  = w_win_id;
      grt_vec = w_keep ? (C_ONE << r_ptr) : w_pick_oh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARBT_NUM; i++) begin
        r_wgt[i] <= '0;
      end
    end else if (wgt_load) begin
      for (int i = 0; i < ARBT_NUM; i++) begin
        r_wgt[i] <= wgt_vec[i*WGT_W +: WGT_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ns_gnrl_wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ns_gnrl_wrr_arbiter                                                     |
// | Vector table plus scoreboard bench for ns_gnrl_wrr_arbiter (4 sources).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ns_gnrl_wrr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vec;
  logic [3:0]  req_last;
  logic [15:0] wgt_vec;
  logic        wgt_load;
  logic        grt_rdy;
  logic        grt_vld;
  logic [3:0]  grt_vec;
  logic [1:0]  grt_id;

  always #5 clk = ~clk;

  ns_gnrl_wrr_arbiter #(
    .ARBT_NUM (4),
    .WGT_W    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vec  (req_vec),
    .req_last (req_last),
    .wgt_vec  (wgt_vec),
    .wgt_load (wgt_load),
    .grt_rdy  (grt_rdy),
    .grt_vld  (grt_vld),
    .grt_vec  (grt_vec),
    .grt_id   (grt_id)
  );

  typedef struct {
    bit          do_rst;
    bit          do_load;
    logic [15:0] wgt;
    logic [3:0]  req;
    logic [3:0]  last;
    bit          rdy;
    bit          exp_vld;
    logic [1:0]  exp_id;
  } vec_t;

  typedef struct {
    logic       vld;
    logic [1:0] id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void add(bit r, bit ld, logic [15:0] w, logic [3:0] rq,
                              logic [3:0] ls, bit rd, bit ev, logic [1:0] ei);
    vec_t v;
    v.do_rst = r;  v.do_load = ld; v.wgt = w;    v.req = rq;
    v.last   = ls; v.rdy     = rd; v.exp_vld = ev; v.exp_id = ei;
    tbl.push_back(v);
  endfunction

  function automatic void expect_grant(bit v, logic [1:0] id);
    exp_t e;
    e.vld = v;
    e.id  = v ? id : 2'd0;
    sb.push_back(e);
  endfunction

  task automatic check(input string name);
    exp_t       e;
    logic [3:0] ev;
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got vld=%b id=%0d", name, grt_vld, grt_id);
      return;
    end
    e  = sb.pop_front();
    ev = e.vld ? (4'b0001 << e.id) : 4'b0000;
    if (grt_vld === e.vld && grt_id === e.id && grt_vec === ev) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got vld=%b id=%0d vec=%b, want vld=%b id=%0d vec=%b",
               name, grt_vld, grt_id, grt_vec, e.vld, e.id, ev);
    end
  endtask

  task automatic step(input logic [3:0] rq, input logic [3:0] ls, input bit rd,
                      input bit ld, input logic [15:0] w,
                      input bit ev, input logic [1:0] ei, input string name);
    @(posedge clk);
    #1;
    req_vec  = rq;
    req_last = ls;
    grt_rdy  = rd;
    wgt_load = ld;
    wgt_vec  = w;
    expect_grant(ev, ei);
    @(negedge clk);
    check(name);
  endtask

  task automatic reset_step(input string name);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    req_vec  = '0;
    wgt_load = 1'b0;
    grt_rdy  = 1'b0;
    expect_grant(1'b0, 2'd0);
    @(negedge clk);
    check(name);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    req_vec  = '0;
    req_last = '0;
    wgt_vec  = '0;
    wgt_load = 1'b0;
    grt_rdy  = 1'b0;

    // Plain round robin with all weights zero.
    add(0,0,16'h0,4'hF,4'hF,1,1,2'd0);
    add(0,0,16'h0,4'hF,4'hF,1,1,2'd1);
    add(0,0,16'h0,4'hF,4'hF,1,1,2'd2);
    add(0,0,16'h0,4'hF,4'hF,1,1,2'd3);
    add(0,0,16'h0,4'hF,4'hF,1,1,2'd0);
    // Weights w3..w0 = {3,0,1,0}.
    add(1,0,16'h0,4'h0,4'hF,0,0,2'd0);
    add(0,1,16'h3010,4'h0,4'hF,1,0,2'd0);
    add(0,0,16'h3010,4'hF,4'hF,1,1,2'd0);
    add(0,0,16'h3010,4'hF,4'hF,1,1,2'd1);
    add(0,0,16'h3010,4'hF,4'hF,1,1,2'd1);
    add(0,0,16'h3010,4'hF,4'hF,1,1,2'd2);
    add(0,0,16'h3010,4'hF,4'hF,1,1,2'd3);
    add(0,0,16'h3010,4'hF,4'hF,1,1,2'd3);
    add(0,0,16'h3010,4'hF,4'hF,1,1,2'd3);
    add(0,0,16'h3010,4'hF,4'hF,1,1,2'd3);
    add(0,0,16'h3010,4'hF,4'hF,1,1,2'd0);
    // Stall holds the grant, then it advances.
    add(1,0,16'h0,4'h0,4'hF,0,0,2'd0);
    add(0,0,16'h0,4'h5,4'hF,0,1,2'd0);
    add(0,0,16'h0,4'h5,4'hF,0,1,2'd0);
    add(0,0,16'h0,4'h5,4'hF,0,1,2'd0);
    add(0,0,16'h0,4'h5,4'hF,1,1,2'd0);
    add(0,0,16'h0,4'h5,4'hF,1,1,2'd2);
    // Owner 1 (weight 3) drops after one beat.
    add(1,0,16'h0,4'h0,4'hF,0,0,2'd0);
    add(0,1,16'h0030,4'h0,4'hF,1,0,2'd0);
    add(0,0,16'h0030,4'hB,4'hF,1,1,2'd0);
    add(0,0,16'h0030,4'hB,4'hF,1,1,2'd1);
    add(0,0,16'h0030,4'h9,4'hF,1,1,2'd3);
    add(0,0,16'h0030,4'h9,4'hF,1,1,2'd0);
    // Load coinciding with a new-winner transfer uses the old weight.
    add(1,0,16'h0,4'h0,4'hF,0,0,2'd0);
    add(0,1,16'h0002,4'h3,4'hF,1,1,2'd0);
    add(0,0,16'h0002,4'h3,4'hF,1,1,2'd1);
    add(0,0,16'h0002,4'h3,4'hF,1,1,2'd0);
    add(0,0,16'h0002,4'h3,4'hF,1,1,2'd0);
    add(0,0,16'h0002,4'h3,4'hF,1,1,2'd0);
    add(0,0,16'h0002,4'h3,4'hF,1,1,2'd1);
    add(1,0,16'h0,4'h0,4'hF,0,0,2'd0);
`ifdef NS_WRR_LOCK_EN
    // Three-beat packet from src 0, then a packet abandoned mid-way.
    add(0,0,16'h0,4'h3,4'h0,1,1,2'd0);
    add(0,0,16'h0,4'h3,4'h0,1,1,2'd0);
    add(0,0,16'h0,4'h3,4'h1,1,1,2'd0);
    add(0,0,16'h0,4'h3,4'h2,1,1,2'd1);
    add(0,0,16'h0,4'h3,4'h0,1,1,2'd0);
    add(0,0,16'h0,4'h2,4'h0,1,0,2'd0);
    add(0,0,16'h0,4'h2,4'h0,1,0,2'd0);
    add(0,0,16'h0,4'h3,4'h1,1,1,2'd0);
    add(0,0,16'h0,4'h3,4'h2,1,1,2'd1);
`else
    // req_last has no effect without the lock feature.
    add(0,0,16'h0,4'h3,4'h0,1,1,2'd0);
    add(0,0,16'h0,4'h3,4'h0,1,1,2'd1);
    add(0,0,16'h0,4'h3,4'h0,1,1,2'd0);
`endif

    expect_grant(1'b0, 2'd0);
    @(negedge clk);
    check("reset_state");
    #2;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) begin
        reset_step($sformatf("vec%0d_rst", i));
      end else begin
        step(tbl[i].req, tbl[i].last, tbl[i].rdy, tbl[i].do_load, tbl[i].wgt,
             tbl[i].exp_vld, tbl[i].exp_id, $sformatf("vec%0d", i));
      end
    end

    // Asynchronous reset in the middle of a weighted (and, if enabled, locked) turn.
    step(4'h0, 4'h0, 1'b1, 1'b1, 16'h3000, 1'b0, 2'd0, "mid_load");
    step(4'h8, 4'h0, 1'b1, 1'b0, 16'h3000, 1'b1, 2'd3, "mid_beat1");
    step(4'h8, 4'h0, 1'b1, 1'b0, 16'h3000, 1'b1, 2'd3, "mid_beat2");
    @(posedge clk);
    #2;
    rst     = 1'b1;
    req_vec = 4'hA;
    #1;
    expect_grant(1'b1, 2'd1);
    check("rst_regrant");
    req_vec = 4'h0;
    #1;
    expect_grant(1'b0, 2'd0);
    check("rst_zero");
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(4'hA, 4'hF, 1'b1, 1'b0, 16'h0, 1'b1, 2'd1, "post_rst0");
    step(4'hA, 4'hF, 1'b1, 1'b0, 16'h0, 1'b1, 2'd3, "post_rst1");
    step(4'hA, 4'hF, 1'b1, 1'b0, 16'h0, 1'b1, 2'd1, "post_rst2");

    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ns_gnrl_wrr_arbiter.md
# ns_gnrl_wrr_arbiter

Parametrised weighted round-robin arbiter with a valid/ready grant handshake, per-requester programmable weights and optional packet locking. It is the successor of the plain round-robin arbiter in the shared `rtl/lib` arbitration set. It is used wherever several sources contend for one downstream port that can back-pressure, for example the bus master mux and the response return path.

## Interface
Parameters:
- ARBT_NUM, default 4: number of requesters, must be at least 2.
- WGT_W, default 4: width of each weight field.
- ID_W, default $clog2(ARBT_NUM): grant index width; derived, never overridden.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- req_vec  in  ARBT_NUM  request per source; a source holds its request until it is granted.
- req_last  in  ARBT_NUM  last beat of a packet, per source; only sampled when NS_WRR_LOCK_EN is defined.
- wgt_vec  in  ARBT_NUM*WGT_W  weights; field i is at [i*WGT_W +: WGT_W].
- wgt_load  in  1  captures wgt_vec into the weight registers.
- grt_rdy  in  1  downstream accepts the granted beat.
- grt_vld  out  1  a grant is presented.
- grt_vec  out  ARBT_NUM  one-hot grant, all zero when grt_vld=0.
- grt_id  out  ID_W  binary index of the grant, 0 when grt_vld=0.

## Operation
- Transfer = grt_vld & grt_rdy. Arbitration state changes only on a transfer, on wgt_load, or on reset.
- Weight w means w+1 consecutive beats per turn. Weight 0 gives plain round-robin.
- State registers:
  - ptr (ID_W): last owner.
  - cred (WGT_W): beats the owner still has left in its turn.
  - own_vld: the owner's turn is still active.
  - locked: packet lock is held.
  - wgt[ARBT_NUM]: the weight registers.
- Winner selection is combinational:
  - If own_vld and req_vec[ptr] and (cred>0 or locked), the winner is ptr.
  - Otherwise the winner is the first requester found in circular search starting at ptr+1, wrapping from ARBT_NUM-1 to 0.
- On a transfer to the current owner: cred <= cred-1, saturating at 0.
- On a transfer to a new winner: ptr <= winner, cred <= wgt[winner], own_vld <= 1.
- After the transfer, own_vld <= 0 when the updated cred is 0 and locked is not set.
- If the owner drops its request while unlocked, its turn ends at once. It keeps no residual credit.
- If the downstream is stalled (grt_rdy=0): grant and state stay frozen for as long as req_vec is stable.
- wgt_load: wgt <= wgt_vec at the clock edge.
  - The new weights apply from the next new-winner selection.
  - A cred value already in flight is not modified.
  - If wgt_load and a new-winner transfer happen in the same cycle, cred loads from the old wgt.
- Reset values:
  - ptr = ARBT_NUM-1, so the first search starts at index 0.
  - cred = 0, own_vld = 0, locked = 0, all wgt = 0.
  - With req_vec=0: grt_vld=0, grt_vec=0, grt_id=0.

## Timing
- Grant latency is zero cycles. grt_* are combinational from req_vec and the registered state; there is no output register.
- The arbitration update is visible in the cycle after a transfer.
- The arbiter sustains one transfer per cycle, with no bubble on a change of owner.
- Asynchronous rst mid-packet clears lock, credit and weights immediately. The grant is re-evaluated from index 0.
- The path from grt_rdy to grt_* is purely registered; there is no combinational loop.

## Configuration
- NS_WRR_LOCK_EN defined:
  - A transfer with req_last[ptr]=0 sets locked. A transfer with req_last[ptr]=1 clears it.
  - While locked, only ptr can be granted, regardless of cred.
  - If ptr deasserts its request while locked, grt_vld=0; other requesters are not served.
- NS_WRR_LOCK_EN undefined:
  - locked is tied to 0 and req_last is ignored.
  - No lock flop is synthesised.

## Structure
- Package ns_arbt_pkg holds:
  - the helper function returning the grant-ID width;
  - the weight type typedef (logic [WGT_W-1:0]);
  - the constant for the reset pointer.
- Sub-module ns_gnrl_rr_pick performs the combinational circular first-one search:
  - Inputs: req_vec and the start index.
  - Outputs: one-hot vector, binary id, found flag.
  - Implementation: double-width masked priority search.
- The top level holds the owner FSM, the credit counter, the weight registers and the lock logic.

## Test plan
- Reset, weights 0, req_vec=4'b1111, grt_rdy=1 constantly -> grt_id sequence 0,1,2,3,0.
- wgt_load with weights {3,0,1,0} (w3..w0), req_vec=4'b1111 -> grt_id sequence 0,1,1,2,3,3,3,3,0.
- req_vec=4'b0101, grt_rdy low for 3 cycles -> grt_id=0 held stable; after grt_rdy rises the next grant goes to id 2.
- Owner 1 with weight 3 drops its request after 1 beat while 4'b1011 is requesting -> next grant is id 3, with no bubble.
- NS_WRR_LOCK_EN defined, weights 0, src 0 sends 3 beats with req_last on the third, src 1 requesting -> grt_id 0,0,0,1. If src 0 deasserts mid-packet, grt_vld=0.
- Assert rst mid-packet while locked -> all outputs zero. Next grant is the lowest requesting index.
